// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel front-end: feeder state encoding and
// default line/row geometry.
package sobel_pkg;

  typedef enum logic [1:0] {
    LOAD1  = 2'd0,
    LOAD2  = 2'd1,
    LOAD3  = 2'd2,
    FILTER = 2'd3
  } feed_state_t;

  localparam int LINE_WORDS_DEF    = 64;
  localparam int ROW_OUT_WORDS_DEF = 64;
  localparam int FRAME_ROWS_DEF    = 480;

  // One-hot line write strobe {line3, line2, line1} for a load state.
  function automatic logic [2:0] line_sel(input feed_state_t s);
    case (s)
      LOAD1:   line_sel = 3'b001;
      LOAD2:   line_sel = 3'b010;
      LOAD3:   line_sel = 3'b100;
      default: line_sel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sobel_line_feeder.sv
// Splits the host row-triple stream onto the three sobel_top line ports and
// holds the filter request until the row's output has fully drained.
//
// state  | meaning
// LOAD1  | accepting words for line 1 (row n-1)
// LOAD2  | accepting words for line 2 (row n)
// LOAD3  | accepting words for line 3 (row n+1)
// FILTER | host stalled, o_filter high, counting drained output beats
module sobel_line_feeder
  import sobel_pkg::*;
#(
  parameter int LINE_WORDS    = LINE_WORDS_DEF,
  parameter int ROW_OUT_WORDS = ROW_OUT_WORDS_DEF,
  parameter int FRAME_ROWS    = FRAME_ROWS_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_data_valid,
  input  logic [63:0] i_data,
  output logic        o_data_ack,
  output logic        o_line1_valid,
  output logic        o_line2_valid,
  output logic        o_line3_valid,
  output logic [63:0] o_line_data,
  output logic        o_filter,
  input  logic        i_out_valid,
  input  logic        i_out_ack,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OW = (ROW_OUT_WORDS > 1) ? $clog2(ROW_OUT_WORDS) : 1;
  localparam int RW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;

  localparam logic [WW-1:0] WORD_LAST = WW'(LINE_WORDS - 1);
  localparam logic [OW-1:0] OUT_LAST  = OW'(ROW_OUT_WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(FRAME_ROWS - 1);

  feed_state_t   state, state_nxt;
  logic [WW-1:0] word_cnt, word_cnt_nxt;
  logic [OW-1:0] out_cnt, out_cnt_nxt;
  logic [RW-1:0] row_cnt, row_cnt_nxt;
  logic [2:0]    strobe_nxt;
  logic [63:0]   data_nxt;
  logic          filter_nxt;
  logic          frame_done_nxt;

  // Ack is masked during reset so the host cannot believe a word was taken.
  assign o_data_ack = i_rst & (state != FILTER);
  assign o_busy     = (state != LOAD1) || (word_cnt != '0);

  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    out_cnt_nxt    = out_cnt;
    row_cnt_nxt    = row_cnt;
    strobe_nxt     = 3'b000;
    data_nxt       = o_line_data;
    frame_done_nxt = 1'b0;

    case (state)
      LOAD1, LOAD2, LOAD3: begin
        if (i_data_valid) begin
          strobe_nxt = line_sel(state);
          data_nxt   = i_data;
          if (word_cnt == WORD_LAST) begin
            word_cnt_nxt = '0;
            case (state)
              LOAD1:   state_nxt = LOAD2;
              LOAD2:   state_nxt = LOAD3;
              default: state_nxt = FILTER;
            endcase
          end else begin
            word_cnt_nxt = word_cnt + WW'(1);
          end
        end
      end
      FILTER: begin
        // Only beats that actually leave sobel_top count toward the row.
        if (i_out_valid && i_out_ack) begin
          if (out_cnt == OUT_LAST) begin
            out_cnt_nxt = '0;
            state_nxt   = LOAD1;
            if (row_cnt == ROW_LAST) begin
              row_cnt_nxt    = '0;
              frame_done_nxt = 1'b1;
            end else begin
              row_cnt_nxt = row_cnt + RW'(1);
            end
          end else begin
            out_cnt_nxt = out_cnt + OW'(1);
          end
        end
      end
      default: state_nxt = LOAD1;
    endcase

    filter_nxt = (state_nxt == FILTER);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= LOAD1;
      word_cnt      <= '0;
      out_cnt       <= '0;
      row_cnt       <= '0;
      o_line1_valid <= 1'b0;
      o_line2_valid <= 1'b0;
      o_line3_valid <= 1'b0;
      o_line_data   <= '0;
      o_filter      <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      state         <= state_nxt;
      word_cnt      <= word_cnt_nxt;
      out_cnt       <= out_cnt_nxt;
      row_cnt       <= row_cnt_nxt;
      o_line1_valid <= strobe_nxt[0];
      o_line2_valid <= strobe_nxt[1];
      o_line3_valid <= strobe_nxt[2];
      o_line_data   <= data_nxt;
      o_filter      <= filter_nxt;
      o_frame_done  <= frame_done_nxt;
    end
  end

endmodule
